game_sequencer: RTL
===================

Name: game_sequencer

Overview:
- Top-level controller for the Tetris datapath: the single FSM that sequences GEN -> MOVE -> LAND -> CLEAR -> NEWBOARD and GAMEOVER.
- Drives the datapath's state/old_state/move inputs.
- Generates the gravity tick and arbitrates player button presses into one move per cycle.
- Monitors the datapath's touched/error flags and the spawn rows of the board to end the game.

Parameters:
- DROP_PERIOD, 16, cycles between gravity ticks in MOVE (min 2).
- CLEAR_CYCLES, 4, cycles spent in CLEAR before NEWBOARD (min 1).
- CNT_W, 8, width of piece counter.

Ports:
- clka  in  1  system clock, single clock domain, rising edge.
- restart  in  1  reset, synchronous, active-high.
- btn_left  in  1  left button level (synchronised upstream).
- btn_right  in  1  right button level.
- btn_rotate  in  1  rotate button level.
- touched  in  1  piece contact flag from datapath, valid in MOVE.
- error_in  in  1  datapath redraw error flag.
- board_in  in  32  current board; bits [31:28] are the spawn row.
- state  out  3  GEN=000, MOVE=001, LAND=010, CLEAR=011, NEWBOARD=100, GAMEOVER=101.
- old_state  out  3  state value of the previous cycle.
- move  out  2  0=none, 1=left, 2=right, 3=rotate; one-cycle pulse.
- drop_tick  out  1  gravity pulse, one cycle.
- game_over  out  1  high while in GAMEOVER.
- piece_count  out  CNT_W  pieces spawned, saturating.

Behaviour:
- Reset (restart=1 at a clka edge) sets: state=GEN, old_state=GEN, move=0, drop_tick=0, game_over=0, piece_count=0, drop timer=0, clear counter=0, pending move=none, button history=0. Reset wins over all other events in every state, including GAMEOVER and mid-CLEAR.
- All outputs are registered. old_state <= state every cycle.
- GEN (1 cycle):
  - If board_in[31:28]!=0, next state is GAMEOVER.
  - Otherwise next state is MOVE and piece_count increments, saturating at all-ones.
- MOVE:
  - Drop timer is 0 on entry and increments each cycle.
  - When timer==DROP_PERIOD-1: drop_tick=1 next cycle and timer wraps to 0.
  - If touched==1 in that same cycle, next state is LAND.
  - touched outside tick cycles is ignored.
- LAND (1 cycle): next state is CLEAR.
- CLEAR:
  - Stays exactly CLEAR_CYCLES cycles, then goes to NEWBOARD.
  - error_in==1 in any CLEAR cycle gives next state GAMEOVER immediately.
- NEWBOARD (1 cycle): next state is GEN.
- GAMEOVER:
  - Absorbing; exit only via restart.
  - game_over=1; move=0; drop_tick=0.
- error_in is ignored outside CLEAR.
- Button handling:
  - Rising-edge detect per button (current level AND NOT previous level).
  - Edges are captured into a one-entry pending slot, only while in MOVE. Edges in any other state are discarded.
  - Simultaneous edges resolve by priority rotate > right > left; the losers are dropped.
  - While pending is occupied, new edges are dropped (no queueing, no overwrite).
  - A pending move issues as move=code for exactly one cycle on the cycle after capture, then the slot clears.
  - If that cycle is a drop_tick cycle, issue is deferred one cycle: move and drop_tick are never both nonzero.
  - If MOVE exits to LAND while a move is pending, the pending move is discarded.
- Held buttons produce only one move; a release and re-press is needed for another.
- move=0 whenever state!=MOVE.

Test Plan:
- Reset, then board_in=0, DROP_PERIOD=4, touched=0 -> GEN one cycle, then MOVE. piece_count=1. drop_tick pulses every 4th cycle. old_state lags state by exactly 1 cycle.
- In MOVE, pulse btn_left for 1 cycle, then hold btn_right 10 cycles -> move=1 for one cycle, then move=2 for exactly one cycle. No further moves while held.
- Rising edges of btn_rotate and btn_left in the same cycle -> single move=3 pulse; no move=1 follows.
- Button edge timed so issue collides with drop_tick -> drop_tick=1 with move=0, then move=code in the next cycle.
- touched=1 held, DROP_PERIOD=4, CLEAR_CYCLES=4 -> MOVE until tick, then LAND 1 cycle, CLEAR 4 cycles, NEWBOARD 1 cycle, GEN, MOVE. piece_count=2.
- Three GAMEOVER paths:
  - board_in[31:28]=4'b0100 at GEN -> GAMEOVER, game_over=1, stays through 20 cycles of button activity.
  - error_in=1 in 2nd CLEAR cycle -> GAMEOVER next cycle.
  - restart=1 -> state=GEN, piece_count=0 on the next edge.

Source files
------------

// File: rtl/game_sequencer_if.sv
// Bundle between the Tetris game sequencer and the rest of the game.
//   master : the sequencer. It drives state/old_state/move/drop_tick/game_over/piece_count.
//            It samples the buttons, the datapath flags and the board.
//   slave  : the datapath/board side, the mirror image of master.
interface game_sequencer_if #(
  parameter int CNT_W = 8
);
  logic             btn_left;
  logic             btn_right;
  logic             btn_rotate;
  logic             touched;
  logic             error_in;
  logic [31:0]      board_in;
  logic [2:0]       state;
  logic [2:0]       old_state;
  logic [1:0]       move;
  logic             drop_tick;
  logic             game_over;
  logic [CNT_W-1:0] piece_count;

  modport master (
    input  btn_left, btn_right, btn_rotate, touched, error_in, board_in,
    output state, old_state, move, drop_tick, game_over, piece_count
  );

  modport slave (
    output btn_left, btn_right, btn_rotate, touched, error_in, board_in,
    input  state, old_state, move, drop_tick, game_over, piece_count
  );
endinterface

// File: rtl/game_sequencer.sv
// Top-level Tetris sequencer.
// It runs GEN -> MOVE -> LAND -> CLEAR -> NEWBOARD -> GEN and can also end in GAMEOVER.
// It times gravity and turns button presses into at most one move pulse per cycle.
// Ports:
//   clka    : clock, rising edge
//   restart : synchronous active-high reset
//   bus     : game_sequencer_if.master
//     inputs : btn_left/right/rotate, touched, error_in, board_in[31:0]
//     outputs: state, old_state, move, drop_tick, game_over, piece_count
// All outputs are registered.
module game_sequencer #(
  parameter int DROP_PERIOD  = 16,
  parameter int CLEAR_CYCLES = 4,
  parameter int CNT_W        = 8
) (
  input  logic                clka,
  input  logic                restart,
  game_sequencer_if.master    bus
);

  localparam int TW = (DROP_PERIOD  > 1) ? $clog2(DROP_PERIOD)  : 1;
  localparam int CW = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_AT  = TW'(DROP_PERIOD - 1);
  localparam logic [CW-1:0] CLEAR_AT = CW'(CLEAR_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_GEN      = 3'd0,
    ST_MOVE     = 3'd1,
    ST_LAND     = 3'd2,
    ST_CLEAR    = 3'd3,
    ST_NEWBOARD = 3'd4,
    ST_GAMEOVER = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    MV_NONE   = 2'd0,
    MV_LEFT   = 2'd1,
    MV_RIGHT  = 2'd2,
    MV_ROTATE = 2'd3
  } move_t;

  state_t           state_q;
  logic [2:0]       old_state_q;
  move_t            move_q;
  logic             drop_tick_q;
  logic             game_over_q;
  logic [CNT_W-1:0] count_q;
  logic [TW-1:0]    timer_q;
  logic [CW-1:0]    clear_q;
  logic             pend_valid_q;
  move_t            pend_code_q;
  logic [2:0]       btn_prev_q;   // {rotate, right, left} from the previous cycle

  logic [2:0] btn_now;
  logic [2:0] btn_rise;
  logic       tick_due;
  move_t      rise_code;

  assign btn_now  = {bus.btn_rotate, bus.btn_right, bus.btn_left};
  assign btn_rise = btn_now & ~btn_prev_q;
  // The tick cycle is the last MOVE cycle of a gravity period.
  // drop_tick becomes visible on the following cycle.
  assign tick_due = (state_q == ST_MOVE) && (timer_q == TICK_AT);
  // Simultaneous edges: rotate beats right beats left.
  assign rise_code = btn_rise[2] ? MV_ROTATE :
                     btn_rise[1] ? MV_RIGHT  : MV_LEFT;

  // NOTE: every register here is assigned with <= so that all of them see the
  // same pre-edge values; a blocking '=' would leak new values into later lines.
  always_ff @(posedge clka) begin
    if (restart) begin
      state_q      <= ST_GEN;
      old_state_q  <= ST_GEN;
      move_q       <= MV_NONE;
      drop_tick_q  <= 1'b0;
      game_over_q  <= 1'b0;
      count_q      <= '0;
      timer_q      <= '0;
      clear_q      <= '0;
      pend_valid_q <= 1'b0;
      pend_code_q  <= MV_NONE;
      btn_prev_q   <= '0;
    end else begin
      old_state_q  <= state_q;
      btn_prev_q   <= btn_now;
      // These are single-cycle pulses.
      // The pending slot and the timer only survive while the state stays in MOVE.
      move_q       <= MV_NONE;
      drop_tick_q  <= 1'b0;
      timer_q      <= '0;
      pend_valid_q <= 1'b0;

      case (state_q)
        ST_GEN: begin
          if (|bus.board_in[31:28]) begin
            state_q     <= ST_GAMEOVER;
            game_over_q <= 1'b1;
          end else begin
            state_q <= ST_MOVE;
            if (count_q != '1) count_q <= count_q + CNT_W'(1);
          end
        end

        ST_MOVE: begin
          drop_tick_q  <= tick_due;
          timer_q      <= tick_due ? '0 : timer_q + TW'(1);
          pend_valid_q <= pend_valid_q;
          if (tick_due && bus.touched) begin
            state_q      <= ST_LAND;
            pend_valid_q <= 1'b0;          // a move that has not issued yet is lost on landing
          end else if (pend_valid_q) begin
            // Hold the move back on the tick cycle so that it never shares a cycle with drop_tick.
            if (!tick_due) begin
              move_q       <= pend_code_q;
              pend_valid_q <= 1'b0;
            end
          end else if (|btn_rise) begin
            pend_valid_q <= 1'b1;
            pend_code_q  <= rise_code;
          end
        end

        ST_LAND: begin
          state_q <= ST_CLEAR;
          clear_q <= '0;
        end

        ST_CLEAR: begin
          if (bus.error_in) begin
            state_q     <= ST_GAMEOVER;
            game_over_q <= 1'b1;
          end else if (clear_q == CLEAR_AT) begin
            state_q <= ST_NEWBOARD;
          end else begin
            clear_q <= clear_q + CW'(1);
          end
        end

        ST_NEWBOARD: state_q <= ST_GEN;

        ST_GAMEOVER: game_over_q <= 1'b1;

        default: begin
          state_q     <= ST_GAMEOVER;
          game_over_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.state       = state_q;
  assign bus.old_state   = old_state_q;
  assign bus.move        = move_q;
  assign bus.drop_tick   = drop_tick_q;
  assign bus.game_over   = game_over_q;
  assign bus.piece_count = count_q;

endmodule
